hypercord_iter_ctrl: RTL and testbench
======================================

Name: hypercord_iter_ctrl

Overview:
- Iterative hyperbolic CORDIC engine. One shared micro-rotation (shift-add) datapath is reused over successive cycles.
- The controller sequences the shift index, including the mandatory hyperbolic repeat iterations at i = 4, 13 and 40.
- Selects rotation or vectoring direction; holds the X/Y/Z working registers.
- Valid/ready on input and output. Sits behind the front-end stages (stage1/stage2 range reduction) as the area-efficient alternative to an unrolled pipeline.

Parameters:
- DWIDTH, IDWIDTH: total fixed-point width (two's complement).
- INT_WIDTH, I_INT_WIDTH: integer bits.
- FRA_WIDTH, I_FRA_WIDTH: fraction bits.
- NITER, 16: last distinct shift index. Indices run 1..NITER; legal range 4..40.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- mode  input  1  0 = rotation (drive Z to 0), 1 = vectoring (drive Y to 0); sampled at accept
- xin  input  DWIDTH  X operand
- yin  input  DWIDTH  Y operand
- zin  input  DWIDTH  Z operand
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- xout  output  DWIDTH  X result
- yout  output  DWIDTH  Y result
- zout  output  DWIDTH  Z result
- busy  output  1  high in any state other than IDLE
- iter_idx  output  6  current shift index (debug/verification)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state = IDLE, X/Y/Z registers = 0, iter_idx = 0, repeat flag = 0. Outputs: in_ready = 1, out_valid = 0, busy = 0.
- FSM states: IDLE, RUN, DONE (plus COMP when the optional feature is enabled).
- IDLE:
  - in_ready = 1.
  - On in_valid: load X/Y/Z and mode, set iter_idx = 1, clear the repeat flag, go to RUN.
- RUN (one micro-rotation per cycle, in_ready = 0):
  - Direction d = +1/−1.
    - Rotation mode: d = +1 if Z ≥ 0, else −1.
    - Vectoring mode: d = −1 if sign(X) == sign(Y), else +1.
  - Update equations:
    - X ← X + d·(Y >>> i)
    - Y ← Y + d·(X >>> i)
    - Z ← Z − d·ATANH_LUT[i]
  - Shifts are arithmetic. Addition wraps modulo 2^DWIDTH; there is no saturation.
  - Index advance:
    - If i ∈ {4, 13, 40} and the repeat flag is 0: keep i and set the flag.
    - Otherwise: i ← i + 1 and clear the flag.
  - The rotation with i == NITER and no pending repeat is the last one; go to DONE on that edge. If NITER is itself a repeat index, it executes twice before DONE.
- Latency:
  - Accept edge = edge 0.
  - Rotations occur on edges 1..T, where T = NITER + (number of repeat indices ≤ NITER). NITER = 16 gives T = 18.
  - out_valid is high from edge T onward.
- DONE:
  - out_valid = 1; xout/yout/zout are driven from the registers and held stable while out_ready = 0.
  - in_ready = 0; there is no same-cycle bypass.
  - When out_ready = 1, go to IDLE. in_ready rises the following cycle.
- in_valid while busy is ignored; the operand is not consumed.
- rst asserted in any state: the next state is IDLE with reset values. Any in-flight operation is discarded and no out_valid pulse is produced.
- The mode input is ignored outside the accept cycle.

Optional Feature:
- Macro: HYPERCORD_GAIN_COMP_EN.
- When defined:
  - After the last rotation the FSM enters COMP for one cycle.
  - X ← (X·INV_KH) >>> FRA_WIDTH and Y ← (Y·INV_KH) >>> FRA_WIDTH; Z is unchanged. Products are truncated.
  - Then DONE; latency = T + 1.
- When undefined: there is no COMP state, the results carry hyperbolic gain Kh ≈ 0.8282, and latency = T.

Decomposition:
- hyperCord_pkg gains:
  - ATANH_LUT: 41 entries, Q(INT_WIDTH.FRA_WIDTH), index 0 unused.
  - INV_KH constant (≈ 1.2075 in the same Q format).
  - Repeat-index set {4, 13, 40}.
  - typedef enum for the FSM states.
  - NITER default.
- Sub-module hc_iter_sched: holds iter_idx and the repeat flag. Outputs the current index, the repeat-pending flag and the last-iteration strobe. Inputs are start and advance.

Test Plan:
- Rotation, HYPERCORD_GAIN_COMP_EN off: X = 1.2075, Y = 0, Z = 0.5 → xout ≈ cosh 0.5 = 1.1276, yout ≈ sinh 0.5 = 0.5211, zout ≈ 0, each within 2^−(NITER−2). out_valid on edge 18 after accept.
- Vectoring: X = 1.0, Y = 0.5, Z = 0 → zout ≈ atanh 0.5 = 0.5493, yout ≈ 0, xout ≈ 0.8282·√0.75 = 0.7172, each within 2^−(NITER−2).
- Schedule check, NITER = 16: iter_idx per RUN cycle = 1,2,3,4,4,5,…,12,13,13,14,15,16 (18 entries). NITER = 13: ends 12,13,13, T = 15.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid → outputs are bit-stable, in_ready = 0, a second in_valid is not accepted. out_ready = 1 → in_ready = 1 on the next cycle.
- Reset mid-run: assert rst at rotation 7 → next cycle in_ready = 1, busy = 0, out_valid = 0, and no result ever appears. A fresh operand afterwards completes normally in 18 cycles.
- With HYPERCORD_GAIN_COMP_EN: repeat the rotation case with X = 1.0 → xout ≈ 1.1276, yout ≈ 0.5211, latency 19.

Source files
------------

// File: rtl/hypercord_iter_ctrl_pkg.sv
// Shared types and constants for the iterative hyperbolic CORDIC engine.
// Optional macro HYPERCORD_GAIN_COMP_EN adds a COMP state that applies 1/Kh to X and Y.
package hypercord_iter_ctrl_pkg;

   // Data format: Q(INT_WIDTH.FRA_WIDTH), two's complement
   localparam int unsigned INT_WIDTH   = 4;
   localparam int unsigned FRA_WIDTH   = 24;
   localparam int unsigned DWIDTH      = INT_WIDTH + FRA_WIDTH;
   // Angle format matches the data format
   localparam int unsigned I_INT_WIDTH = INT_WIDTH;
   localparam int unsigned I_FRA_WIDTH = FRA_WIDTH;
   localparam int unsigned IDWIDTH     = I_INT_WIDTH + I_FRA_WIDTH;

   localparam int unsigned ITW         = 6;
   localparam int unsigned NITER_DEF   = 16;

   // Indices that must run twice for hyperbolic convergence
   localparam int unsigned RPT_IDX_A   = 4;
   localparam int unsigned RPT_IDX_B   = 13;
   localparam int unsigned RPT_IDX_C   = 40;

   // 1/Kh ~= 1.2074970678
   localparam logic [DWIDTH-1:0] INV_KH = DWIDTH'(20258439);

   // atanh(2^-i), rounded; entry 0 is never addressed
   localparam logic [IDWIDTH-1:0] ATANH_LUT [0:40] = '{
      IDWIDTH'(0),       IDWIDTH'(9215828), IDWIDTH'(4285116), IDWIDTH'(2108178),
      IDWIDTH'(1049945), IDWIDTH'(524459),  IDWIDTH'(262165),  IDWIDTH'(131075),
      IDWIDTH'(65536),   IDWIDTH'(32768),   IDWIDTH'(16384),   IDWIDTH'(8192),
      IDWIDTH'(4096),    IDWIDTH'(2048),    IDWIDTH'(1024),    IDWIDTH'(512),
      IDWIDTH'(256),     IDWIDTH'(128),     IDWIDTH'(64),      IDWIDTH'(32),
      IDWIDTH'(16),      IDWIDTH'(8),       IDWIDTH'(4),       IDWIDTH'(2),
      IDWIDTH'(1),       IDWIDTH'(0),       IDWIDTH'(0),       IDWIDTH'(0),
      IDWIDTH'(0),       IDWIDTH'(0),       IDWIDTH'(0),       IDWIDTH'(0),
      IDWIDTH'(0),       IDWIDTH'(0),       IDWIDTH'(0),       IDWIDTH'(0),
      IDWIDTH'(0),       IDWIDTH'(0),       IDWIDTH'(0),       IDWIDTH'(0),
      IDWIDTH'(0)
   };

`ifdef HYPERCORD_GAIN_COMP_EN
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_COMP, ST_DONE} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
`endif

   // True when index i belongs to the repeat set
   function automatic logic is_rpt_idx(input logic [ITW-1:0] i);
      return (i == ITW'(RPT_IDX_A)) || (i == ITW'(RPT_IDX_B)) || (i == ITW'(RPT_IDX_C));
   endfunction

endpackage

// File: rtl/hc_iter_sched.sv
// Shift-index scheduler: walks 1..NITER and runs each repeat index twice.
module hc_iter_sched
   import hypercord_iter_ctrl_pkg::*;
#(
   parameter int unsigned NITER = NITER_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           advance,
   output logic [ITW-1:0] idx,
   output logic           rpt_pend_c,
   output logic           last_idx_c
);

   logic rpt_done;

   // Index and repeat-flag register
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         rpt_done <= 1'b0;
      end else if (start) begin
         idx      <= ITW'(1);
         rpt_done <= 1'b0;
      end else if (advance) begin
         if (rpt_pend_c) begin
            rpt_done <= 1'b1;
         end else begin
            idx      <= idx + ITW'(1);
            rpt_done <= 1'b0;
         end
      end
   end

   // Current rotation will be repeated / index has reached NITER
   assign rpt_pend_c = is_rpt_idx(idx) && !rpt_done;
   assign last_idx_c = (idx == ITW'(NITER));

endmodule

// File: rtl/hypercord_iter_ctrl.sv
// Iterative hyperbolic CORDIC: one shared shift-add stage, valid/ready on both sides.
// Optional macro HYPERCORD_GAIN_COMP_EN adds a one-cycle 1/Kh gain correction.
module hypercord_iter_ctrl
   import hypercord_iter_ctrl_pkg::*;
#(
   parameter int unsigned NITER = NITER_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              mode,
   input  logic [DWIDTH-1:0] xin,
   input  logic [DWIDTH-1:0] yin,
   input  logic [DWIDTH-1:0] zin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] xout,
   output logic [DWIDTH-1:0] yout,
   output logic [DWIDTH-1:0] zout,
   output logic              busy,
   output logic [ITW-1:0]    iter_idx
);

   state_t state, state_n;
   logic   in_ready_n, out_valid_n, busy_n;
   logic   load, rotate;
   logic   rpt_pend_c, last_idx_c;
   logic   mode_q;
   logic   dir_pos;
   logic signed [DWIDTH-1:0] x, y, z;
   logic signed [DWIDTH-1:0] x_sh, y_sh, ang;
   logic signed [DWIDTH-1:0] x_rot, y_rot, z_rot;
`ifdef HYPERCORD_GAIN_COMP_EN
   localparam int unsigned PW = 2 * DWIDTH;
   logic comp;
   logic signed [PW-1:0] x_prod, y_prod;
`endif

   hc_iter_sched #(.NITER(NITER)) u_sched (
      .clk        (clk),
      .rst        (rst),
      .start      (load),
      .advance    (rotate),
      .idx        (iter_idx),
      .rpt_pend_c (rpt_pend_c),
      .last_idx_c (last_idx_c)
   );

   // One micro-rotation with direction chosen by mode
   always_comb begin
      x_sh    = x >>> iter_idx;
      y_sh    = y >>> iter_idx;
      ang     = $signed(ATANH_LUT[iter_idx]);
      dir_pos = mode_q ? (x[DWIDTH-1] != y[DWIDTH-1]) : ~z[DWIDTH-1];
      if (dir_pos) begin
         x_rot = x + y_sh;
         y_rot = y + x_sh;
         z_rot = z - ang;
      end else begin
         x_rot = x - y_sh;
         y_rot = y - x_sh;
         z_rot = z + ang;
      end
   end

`ifdef HYPERCORD_GAIN_COMP_EN
   // Full-width products for the 1/Kh correction, truncated on use
   always_comb begin
      x_prod = PW'(x) * PW'($signed(INV_KH));
      y_prod = PW'(y) * PW'($signed(INV_KH));
   end
`endif

   // Next-state, datapath strobes and next values of the registered handshake outputs
   always_comb begin
      state_n = state;
      load    = 1'b0;
      rotate  = 1'b0;
`ifdef HYPERCORD_GAIN_COMP_EN
      comp    = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               load    = 1'b1;
               state_n = ST_RUN;
            end
         end
         ST_RUN: begin
            rotate = 1'b1;
            if (last_idx_c && !rpt_pend_c) begin
`ifdef HYPERCORD_GAIN_COMP_EN
               state_n = ST_COMP;
`else
               state_n = ST_DONE;
`endif
            end
         end
`ifdef HYPERCORD_GAIN_COMP_EN
         ST_COMP: begin
            comp    = 1'b1;
            state_n = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (out_ready) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
      in_ready_n  = (state_n == ST_IDLE);
      out_valid_n = (state_n == ST_DONE);
      busy_n      = (state_n != ST_IDLE);
   end

   // State register and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         in_ready  <= in_ready_n;
         out_valid <= out_valid_n;
         busy      <= busy_n;
      end
   end

   // X/Y/Z working registers and captured mode
   always_ff @(posedge clk) begin
      if (rst) begin
         x      <= '0;
         y      <= '0;
         z      <= '0;
         mode_q <= 1'b0;
      end else if (load) begin
         x      <= $signed(xin);
         y      <= $signed(yin);
         z      <= $signed(zin);
         mode_q <= mode;
      end else if (rotate) begin
         x <= x_rot;
         y <= y_rot;
         z <= z_rot;
`ifdef HYPERCORD_GAIN_COMP_EN
      end else if (comp) begin
         x <= DWIDTH'(x_prod >>> FRA_WIDTH);
         y <= DWIDTH'(y_prod >>> FRA_WIDTH);
`endif
      end
   end

   assign xout = x;
   assign yout = y;
   assign zout = z;

endmodule

// File: tb/tb_hypercord_iter_ctrl.sv
// Directed bench for hypercord_iter_ctrl with a real-valued reference model and scoreboard.
// Honours HYPERCORD_GAIN_COMP_EN (adds one cycle of latency and removes the Kh gain).
module tb_hypercord_iter_ctrl;
   import hypercord_iter_ctrl_pkg::*;

`ifdef HYPERCORD_GAIN_COMP_EN
   localparam int  COMP_LAT = 1;
   localparam real GAIN_FIX = 1.2074970677630724;
   localparam real X_ROT    = 1.0;
`else
   localparam int  COMP_LAT = 0;
   localparam real GAIN_FIX = 1.0;
   localparam real X_ROT    = 1.2075;
`endif

   typedef struct {
      real x;
      real y;
      real z;
   } res_t;

   logic              clk, rst, in_valid, in_valid13, mode, out_ready;
   logic [DWIDTH-1:0] xin, yin, zin;
   logic              in_ready, out_valid, busy;
   logic [DWIDTH-1:0] xout, yout, zout;
   logic [ITW-1:0]    iter_idx;
   logic              in_ready13, out_valid13, busy13;
   logic [DWIDTH-1:0] xout13, yout13, zout13;
   logic [ITW-1:0]    iter_idx13;

   res_t sbq[$];
   int   vectors     = 0;
   int   miscompares = 0;

   hypercord_iter_ctrl #(.NITER(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .xin(xin), .yin(yin), .zin(zin), .out_valid(out_valid), .out_ready(out_ready),
      .xout(xout), .yout(yout), .zout(zout), .busy(busy), .iter_idx(iter_idx)
   );

   hypercord_iter_ctrl #(.NITER(13)) dut13 (
      .clk(clk), .rst(rst), .in_valid(in_valid13), .in_ready(in_ready13), .mode(mode),
      .xin(xin), .yin(yin), .zin(zin), .out_valid(out_valid13), .out_ready(out_ready),
      .xout(xout13), .yout(yout13), .zout(zout13), .busy(busy13), .iter_idx(iter_idx13)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DWIDTH-1:0] r2fx(input real r);
      return DWIDTH'($rtoi(r * (2.0 ** FRA_WIDTH)));
   endfunction

   function automatic real fx2r(input logic [DWIDTH-1:0] v);
      return real'($signed(v)) / (2.0 ** FRA_WIDTH);
   endfunction

   // Number of rotations for a given NITER (repeats at 4, 13, 40)
   function automatic int sched_len(input int n);
      int c = 0;
      for (int i = 1; i <= n; i++) c += (i == 4 || i == 13 || i == 40) ? 2 : 1;
      return c;
   endfunction

   // Shift index used by rotation k (0-based)
   function automatic int sched_at(input int n, input int k);
      int c = 0;
      for (int i = 1; i <= n; i++) begin
         if (c == k) return i;
         c++;
         if (i == 4 || i == 13 || i == 40) begin
            if (c == k) return i;
            c++;
         end
      end
      return -1;
   endfunction

   function automatic real kh(input int n);
      real p = 1.0;
      for (int k = 0; k < sched_len(n); k++)
         p = p * $sqrt(1.0 - 2.0 ** (-2.0 * real'(sched_at(n, k))));
      return p;
   endfunction

   function automatic res_t model(input logic m, input real x, input real y, input real z,
                                  input int n);
      res_t r;
      real  g = kh(n) * GAIN_FIX;
      if (!m) begin
         r.x = g * (x * $cosh(z) + y * $sinh(z));
         r.y = g * (y * $cosh(z) + x * $sinh(z));
         r.z = 0.0;
      end else begin
         r.x = g * $sqrt(x * x - y * y);
         r.y = 0.0;
         r.z = z + $atanh(y / x);
      end
      return r;
   endfunction

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input real obs, input real exp, input real tol);
      vectors++;
      assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
         miscompares++;
         $error("FAIL %s observed=%f expected=%f tol=%f", tag, obs, exp, tol);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   // One operand through the NITER=16 instance, with optional schedule check and stall
   task automatic run16(input string nm, input logic m, input real x, input real y,
                        input real z, input bit chk_sched, input int hold);
      int   n;
      res_t e;
      real  tol = 2.0 ** (-14.0);
      xin = r2fx(x); yin = r2fx(y); zin = r2fx(z); mode = m; in_valid = 1'b1;
      sbq.push_back(model(m, fx2r(xin), fx2r(yin), fx2r(zin), 16));
      chk_eq({nm, "_ready_at_accept"}, 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0; mode = ~m; xin = '1; yin = '1; zin = '1;
      chk_eq({nm, "_busy"}, 64'(busy), 64'd1);
      chk_eq({nm, "_in_ready_run"}, 64'(in_ready), 64'd0);
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
         if (chk_sched && n < sched_len(16))
            chk_eq($sformatf("%s_sched%0d", nm, n), 64'(iter_idx), 64'(sched_at(16, n)));
         step();
         n++;
      end
      chk_eq({nm, "_latency"}, 64'(n), 64'(sched_len(16) + COMP_LAT));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1; xin = r2fx(0.3); yin = r2fx(0.1); zin = r2fx(0.2);
         chk_near($sformatf("%s_hold%0d_x", nm, h), fx2r(xout), sbq[0].x, tol);
         chk_near($sformatf("%s_hold%0d_z", nm, h), fx2r(zout), sbq[0].z, tol);
         chk_eq($sformatf("%s_hold%0d_in_ready", nm, h), 64'(in_ready), 64'd0);
         chk_eq($sformatf("%s_hold%0d_out_valid", nm, h), 64'(out_valid), 64'd1);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      e = sbq.pop_front();
      chk_near({nm, "_x"}, fx2r(xout), e.x, tol);
      chk_near({nm, "_y"}, fx2r(yout), e.y, tol);
      chk_near({nm, "_z"}, fx2r(zout), e.z, tol);
      step();
      out_ready = 1'b0;
      chk_eq({nm, "_in_ready_after"}, 64'(in_ready), 64'd1);
      chk_eq({nm, "_out_valid_after"}, 64'(out_valid), 64'd0);
      chk_eq({nm, "_busy_after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int   n;
      bit   seen;
      res_t e13;
      rst = 1'b1; in_valid = 1'b0; in_valid13 = 1'b0; mode = 1'b0; out_ready = 1'b0;
      xin = '0; yin = '0; zin = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_eq("rst_in_ready", 64'(in_ready), 64'd1);
      chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
      chk_eq("rst_busy", 64'(busy), 64'd0);
      chk_eq("rst_iter_idx", 64'(iter_idx), 64'd0);
      chk_eq("rst_xout", 64'(xout), 64'd0);
      chk_eq("rst_in_ready13", 64'(in_ready13), 64'd1);

      // Rotation with schedule trace and a 5-cycle stall
      run16("rot", 1'b0, X_ROT, 0.0, 0.5, 1'b1, 5);
      // Vectoring
      run16("vec", 1'b1, 1.0, 0.5, 0.0, 1'b0, 0);

      // Reset during rotation 7: operation discarded
      xin = r2fx(X_ROT); yin = '0; zin = r2fx(0.5); mode = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (6) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_eq("mrst_in_ready", 64'(in_ready), 64'd1);
      chk_eq("mrst_busy", 64'(busy), 64'd0);
      chk_eq("mrst_out_valid", 64'(out_valid), 64'd0);
      chk_eq("mrst_iter_idx", 64'(iter_idx), 64'd0);
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         seen |= (out_valid !== 1'b0) || (busy !== 1'b0);
         step();
      end
      chk_eq("mrst_no_result", 64'(seen), 64'd0);
      run16("post_rst", 1'b0, X_ROT, 0.0, 0.5, 1'b0, 0);

      // NITER = 13 instance: schedule tail and latency
      xin = r2fx(X_ROT); yin = '0; zin = r2fx(0.5); mode = 1'b0; in_valid13 = 1'b1;
      e13 = model(1'b0, fx2r(xin), fx2r(yin), fx2r(zin), 13);
      step();
      in_valid13 = 1'b0;
      n = 0;
      while (out_valid13 !== 1'b1 && n < 200) begin
         if (n < sched_len(13))
            chk_eq($sformatf("n13_sched%0d", n), 64'(iter_idx13), 64'(sched_at(13, n)));
         step();
         n++;
      end
      chk_eq("n13_latency", 64'(n), 64'(15 + COMP_LAT));
      chk_near("n13_x", fx2r(xout13), e13.x, 2.0 ** (-11.0));
      chk_near("n13_y", fx2r(yout13), e13.y, 2.0 ** (-11.0));
      chk_near("n13_z", fx2r(zout13), e13.z, 2.0 ** (-11.0));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_eq("n13_in_ready_after", 64'(in_ready13), 64'd1);
      chk_eq("n13_busy_after", 64'(busy13), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
